// File: rtl/jk_exciter.sv
// jk_exciter
//
// Write-side controller for an external bank of JK flip-flops. A target word
// is accepted over a valid/ready handshake. The block compares it with the
// bank's present state and computes per-bit J/K excitation. It issues a
// one-cycle strobe to the bank, waits for the bank to settle, then re-reads
// the bank to confirm the write. If the bank still disagrees with the target,
// the write is retried a bounded number of times. A one-cycle done pulse then
// reports success or error.
//
// Parameters
//   WIDTH       bits in the target word and in the JK bank
//   SETTLE_CYC  cycles waited after a strobe before q_fb is compared (>= 1)
//   MAX_RETRY   extra strobes allowed after the first before err (0..15)
//   DC_VAL      level driven on don't-care excitation inputs
//               (0 = set/reset style, 1 = toggle style)
//
// Ports
//   ck         in   1      clock, all state updates on the rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      target word valid
//   in_ready   out  1      block can accept a word (high only while idle)
//   in_data    in   WIDTH  target word
//   q_fb       in   WIDTH  present state of the JK bank
//   j          out  WIDTH  J excitation, registered
//   k          out  WIDTH  K excitation, registered
//   jk_strobe  out  1      one-cycle enable for the JK bank
//   done       out  1      one-cycle completion pulse
//   err        out  1      qualified by done: 1 = bank never matched target
//   retries    out  4      strobes issued minus one for the last operation

module jk_exciter #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned MAX_RETRY  = 2,
    parameter bit          DC_VAL     = 1'b0
) (
    input  logic             ck,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             jk_strobe,
    output logic             done,
    output logic             err,
    output logic [3:0]       retries
);

    localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] tgt_nx;
    logic [WIDTH-1:0] j_nx;
    logic [WIDTH-1:0] k_nx;
    logic             strobe_nx;
    logic             done_nx;
    logic             err_nx;
    logic [3:0]       retries_nx;
    logic [SCW-1:0]   settle_cnt;
    logic [SCW-1:0]   settle_cnt_nx;

    // JK excitation table: a bit currently at 0 only needs J to pick its
    // next value, and a bit at 1 only needs K. The input that does not
    // matter is driven with DC_VAL.
    function automatic logic [WIDTH-1:0] excite_j(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] t);
        return (~cur & t) | (cur & {WIDTH{DC_VAL}});
    endfunction

    function automatic logic [WIDTH-1:0] excite_k(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] t);
        return (cur & ~t) | (~cur & {WIDTH{DC_VAL}});
    endfunction

    assign in_ready = (state == IDLE);

    // All outputs are registered. The next-state logic computes their next
    // values, so j/k/jk_strobe are non-zero only during the DRIVE cycle. The
    // excitation is always taken from the q_fb value present on the edge
    // that enters DRIVE.
    always_comb begin
        state_nx      = state;
        tgt_nx        = tgt;
        j_nx          = '0;
        k_nx          = '0;
        strobe_nx     = 1'b0;
        done_nx       = 1'b0;
        err_nx        = 1'b0;
        retries_nx    = retries;
        settle_cnt_nx = settle_cnt;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    tgt_nx     = in_data;
                    retries_nx = 4'd0;
                    // A bank that already holds the target needs no strobe.
                    if (q_fb == in_data) begin
                        state_nx = CHECK;
                    end else begin
                        state_nx  = DRIVE;
                        j_nx      = excite_j(q_fb, in_data);
                        k_nx      = excite_k(q_fb, in_data);
                        strobe_nx = 1'b1;
                    end
                end
            end

            DRIVE: begin
                state_nx      = SETTLE;
                settle_cnt_nx = '0;
            end

            SETTLE: begin
                if (settle_cnt == SCW'(SETTLE_CYC - 1)) begin
                    state_nx = CHECK;
                end else begin
                    settle_cnt_nx = settle_cnt + SCW'(1);
                end
            end

            CHECK: begin
                if (q_fb == tgt) begin
                    state_nx = RESP;
                    done_nx  = 1'b1;
                end else if (retries < 4'(MAX_RETRY)) begin
                    // Recompute from the bank's current state, because a
                    // partial write may have changed some bits already.
                    retries_nx = retries + 4'd1;
                    state_nx   = DRIVE;
                    j_nx       = excite_j(q_fb, tgt);
                    k_nx       = excite_k(q_fb, tgt);
                    strobe_nx  = 1'b1;
                end else begin
                    state_nx = RESP;
                    done_nx  = 1'b1;
                    err_nx   = 1'b1;
                end
            end

            RESP: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Asserting reset aborts any operation in flight without a done pulse.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tgt        <= '0;
            j          <= '0;
            k          <= '0;
            jk_strobe  <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            retries    <= 4'd0;
            settle_cnt <= '0;
        end else begin
            state      <= state_nx;
            tgt        <= tgt_nx;
            j          <= j_nx;
            k          <= k_nx;
            jk_strobe  <= strobe_nx;
            done       <= done_nx;
            err        <= err_nx;
            retries    <= retries_nx;
            settle_cnt <= settle_cnt_nx;
        end
    end

endmodule

// File: tb/tb_jk_exciter.sv
// tb_jk_exciter
//
// Bench for jk_exciter with WIDTH=4, SETTLE_CYC=1 and MAX_RETRY=2. Two
// instances run side by side, one with set/reset style don't-cares
// (DC_VAL=0) and one with toggle style (DC_VAL=1). Each instance drives its
// own behavioural JK bank. A bank can have stuck-at-0 bits through a mask.
// Expected timing, excitation and status come from an operation-level model.

module tb_jk_exciter;

    localparam int W   = 4;
    localparam int SC  = 1;
    localparam int MR  = 2;
    localparam int PER = 2 + SC;

    logic         ck;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] in_data;

    logic [W-1:0] q_fb0, q_fb1;
    logic [W-1:0] j0, k0, j1, k1;
    logic         in_ready0, in_ready1;
    logic         jk_strobe0, jk_strobe1;
    logic         done0, done1, err0, err1;
    logic [3:0]   retries0, retries1;

    logic [W-1:0] bank0, bank1;
    logic [W-1:0] stuck_mask;
    logic [W-1:0] preload_val;
    logic         preload_en;

    int n_checks;
    int n_fail;

    jk_exciter #(.WIDTH(W), .SETTLE_CYC(SC), .MAX_RETRY(MR), .DC_VAL(1'b0)) u_dut0 (
        .ck        (ck),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready0),
        .in_data   (in_data),
        .q_fb      (q_fb0),
        .j         (j0),
        .k         (k0),
        .jk_strobe (jk_strobe0),
        .done      (done0),
        .err       (err0),
        .retries   (retries0)
    );

    jk_exciter #(.WIDTH(W), .SETTLE_CYC(SC), .MAX_RETRY(MR), .DC_VAL(1'b1)) u_dut1 (
        .ck        (ck),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .in_data   (in_data),
        .q_fb      (q_fb1),
        .j         (j1),
        .k         (k1),
        .jk_strobe (jk_strobe1),
        .done      (done1),
        .err       (err1),
        .retries   (retries1)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    // Ideal JK flop characteristic: hold, reset, set, toggle.
    function automatic logic [W-1:0] jk_update(input logic [W-1:0] q,
                                               input logic [W-1:0] jj,
                                               input logic [W-1:0] kk);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            case ({jj[i], kk[i]})
                2'b00:   r[i] = q[i];
                2'b01:   r[i] = 1'b0;
                2'b10:   r[i] = 1'b1;
                default: r[i] = ~q[i];
            endcase
        end
        return r;
    endfunction

    always @(posedge ck) begin
        if (preload_en) begin
            bank0 <= preload_val;
            bank1 <= preload_val;
        end else begin
            if (jk_strobe0) bank0 <= jk_update(bank0, j0, k0);
            if (jk_strobe1) bank1 <= jk_update(bank1, j1, k1);
        end
    end

    assign q_fb0 = bank0 & ~stuck_mask;
    assign q_fb1 = bank1 & ~stuck_mask;

    // Excitation each bit needs to reach t from cur; dc fills the unused input.
    function automatic logic [W-1:0] exp_j(input logic [W-1:0] cur,
                                           input logic [W-1:0] t, input bit dc);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = cur[i] ? dc : t[i];
        return r;
    endfunction

    function automatic logic [W-1:0] exp_k(input logic [W-1:0] cur,
                                           input logic [W-1:0] t, input bit dc);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = cur[i] ? ~t[i] : dc;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one write operation and checks every cycle from accept to done.
    // Set preload to load the bank (and stuck mask) first. Set hold to keep
    // in_valid high with unrelated data during the operation.
    task automatic applyStimulus(input logic [W-1:0] init_q, input logic [W-1:0] tgt,
                                 input logic [W-1:0] stuck, input bit preload,
                                 input bit hold);
        logic [W-1:0] cur_q[$];
        logic [W-1:0] cur;
        logic [W-1:0] scur;
        logic [W-1:0] ej0, ek0, ej1, ek1;
        int           n;
        int           exp_done;
        int           exp_ret;
        bit           exp_err;
        bit           strobe_now;

        if (preload) begin
            @(negedge ck);
            stuck_mask  = stuck;
            preload_val = init_q;
            preload_en  = 1'b1;
            @(negedge ck);
            preload_en  = 1'b0;
        end

        // Operation-level model: every strobe writes the target except the
        // stuck bits. Strobing stops on a match or after MR+1 strobes.
        cur = init_q & ~stuck;
        n   = 0;
        if (cur != tgt) begin
            do begin
                cur_q.push_back(cur);
                n++;
                cur = tgt & ~stuck;
            end while (cur != tgt && n < MR + 1);
        end
        exp_err  = (cur != tgt);
        exp_ret  = (n == 0) ? 0 : n - 1;
        exp_done = (n == 0) ? 2 : n * PER + 1;

        @(negedge ck);
        checkOutput("ready_before_accept", 32'(in_ready0), 32'd1);
        in_valid = 1'b1;
        in_data  = tgt;
        @(posedge ck);
        #1;
        if (hold) in_data = ~tgt;
        else      in_valid = 1'b0;

        for (int c = 1; c <= exp_done; c++) begin
            @(negedge ck);
            strobe_now = (n > 0) && ((c - 1) % PER == 0) && ((c - 1) / PER < n);
            scur = strobe_now ? cur_q[(c - 1) / PER] : '0;
            ej0  = strobe_now ? exp_j(scur, tgt, 1'b0) : '0;
            ek0  = strobe_now ? exp_k(scur, tgt, 1'b0) : '0;
            ej1  = strobe_now ? exp_j(scur, tgt, 1'b1) : '0;
            ek1  = strobe_now ? exp_k(scur, tgt, 1'b1) : '0;
            checkOutput("strobe0", 32'(jk_strobe0), 32'(strobe_now));
            checkOutput("strobe1", 32'(jk_strobe1), 32'(strobe_now));
            checkOutput("j0", 32'(j0), 32'(ej0));
            checkOutput("k0", 32'(k0), 32'(ek0));
            checkOutput("j1", 32'(j1), 32'(ej1));
            checkOutput("k1", 32'(k1), 32'(ek1));
            checkOutput("done0", 32'(done0), 32'(c == exp_done));
            checkOutput("done1", 32'(done1), 32'(c == exp_done));
            checkOutput("busy_ready0", 32'(in_ready0), 32'd0);
            checkOutput("busy_ready1", 32'(in_ready1), 32'd0);
            if (c == exp_done) begin
                checkOutput("err0", 32'(err0), 32'(exp_err));
                checkOutput("err1", 32'(err1), 32'(exp_err));
                checkOutput("retries0", 32'(retries0), 32'(exp_ret));
                checkOutput("retries1", 32'(retries1), 32'(exp_ret));
                checkOutput("q_final0", 32'(q_fb0), 32'(cur));
                checkOutput("q_final1", 32'(q_fb1), 32'(cur));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        stuck_mask  = '0;
        preload_val = '0;
        preload_en  = 1'b1;

        @(negedge ck);
        checkOutput("rst_ready", 32'(in_ready0), 32'd1);
        checkOutput("rst_j", 32'(j0), 32'd0);
        checkOutput("rst_k", 32'(k0), 32'd0);
        checkOutput("rst_strobe", 32'(jk_strobe0), 32'd0);
        checkOutput("rst_done", 32'(done0), 32'd0);
        checkOutput("rst_err", 32'(err0), 32'd0);
        checkOutput("rst_retries", 32'(retries0), 32'd0);
        rst_n      = 1'b1;
        preload_en = 1'b0;

        // Directed cases
        applyStimulus(4'b0000, 4'b1010, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b1100, 4'b1010, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0110, 4'b0110, 4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0001, 4'b0001, 1'b1, 1'b0);
        @(negedge ck);
        checkOutput("retries_held", 32'(retries0), 32'd2);

        // Reset during SETTLE aborts the operation with no done pulse.
        @(negedge ck);
        stuck_mask  = '0;
        preload_val = 4'b0000;
        preload_en  = 1'b1;
        @(negedge ck);
        preload_en  = 1'b0;
        @(negedge ck);
        in_valid = 1'b1;
        in_data  = 4'b1010;
        @(posedge ck);
        #1;
        in_valid = 1'b0;
        @(negedge ck);
        checkOutput("abort_strobe", 32'(jk_strobe0), 32'd1);
        @(negedge ck);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", 32'(in_ready0), 32'd1);
        checkOutput("abort_strobe_low", 32'(jk_strobe0), 32'd0);
        checkOutput("abort_done", 32'(done0), 32'd0);
        checkOutput("abort_err", 32'(err0), 32'd0);
        checkOutput("abort_retries", 32'(retries0), 32'd0);
        @(negedge ck);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge ck);
            checkOutput("abort_no_done", 32'(done0), 32'd0);
        end
        applyStimulus(4'b1010, 4'b0101, 4'b0000, 1'b0, 1'b0);

        // Back-to-back operations with in_valid held high during each one
        applyStimulus(4'b0011, 4'b1001, 4'b0000, 1'b1, 1'b1);
        applyStimulus(4'b1001, 4'b0100, 4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0100, 4'b1111, 4'b0000, 1'b0, 1'b0);

        // Randomized operations, some with stuck bits
        for (int r = 0; r < 24; r++) begin
            logic [W-1:0] ri, rt, rs;
            ri = W'($urandom);
            rt = W'($urandom);
            rs = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            applyStimulus(ri, rt, rs, 1'b1, 1'b0);
        end

        @(negedge ck);
        checkOutput("idle_ready_end", 32'(in_ready0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
